// File: rtl/pkt_formatter_if.sv
// Handshake bundle between the packet formatter, its upstream FIFO
// and the downstream arbiter/consumer.
interface pkt_formatter_if #(
    parameter int DW            = 32,
    parameter int FIFO_PTR_WIDE = 3
);
    logic [3:0]             pkt_len;
    logic [FIFO_PTR_WIDE:0] fifo_slack;
    logic                   downlink_ready;
    logic [DW-1:0]          fifo_rdata;
    logic                   fifo_rd_en;
    logic                   fmt_req;
    logic                   fmt_grant;
    logic                   fmt_valid;
    logic                   fmt_start;
    logic                   fmt_end;
    logic [DW-1:0]          fmt_data;
    logic [3:0]             fmt_length;
    logic [15:0]            pkt_cnt;
    logic                   err_underflow;

    modport master (
        input  pkt_len, fifo_slack, downlink_ready, fifo_rdata, fmt_grant,
        output fifo_rd_en, fmt_req, fmt_valid, fmt_start, fmt_end,
        output fmt_data, fmt_length, pkt_cnt, err_underflow
    );

    modport slave (
        output pkt_len, fifo_slack, downlink_ready, fifo_rdata, fmt_grant,
        input  fifo_rd_en, fmt_req, fmt_valid, fmt_start, fmt_end,
        input  fmt_data, fmt_length, pkt_cnt, err_underflow
    );
endinterface

// File: rtl/pkt_formatter.sv
// Packet formatter: waits for enough FIFO words, requests a slot,
// then streams a framed packet of fmt_length words downstream.
module pkt_formatter #(
    parameter int DW            = 32,
    parameter int FIFO_PTR_WIDE = 3,
    parameter int MAX_CNT       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pkt_formatter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SEND, LAST} state_t;

    localparam int OW = FIFO_PTR_WIDE + 2;
    localparam logic [3:0] MAXL = 4'(MAX_CNT);

    state_t      state;
    logic [3:0]  beat;
    logic [3:0]  len_q;
    logic [15:0] cnt;
    logic        req_q;
    logic        valid_q;
    logic        start_q;
    logic        end_q;
    logic        err_q;

    logic [OW-1:0] occ;
    logic [3:0]    len_eff;
    logic          start_ok;
    logic          rd;
    logic          last_rd;

    assign occ      = OW'(MAX_CNT) - OW'(bus.fifo_slack);
    assign len_eff  = (bus.pkt_len > MAXL) ? MAXL : bus.pkt_len;
    assign start_ok = (len_eff != 4'd0) && (int'(occ) >= int'(len_eff));
    assign rd       = (state == SEND) && bus.downlink_ready;
    assign last_rd  = rd && ((beat + 4'd1) == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            beat    <= 4'd0;
            len_q   <= 4'd0;
            cnt     <= 16'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Read data arrives one cycle after the strobe, so framing lags too
            valid_q <= rd;
            start_q <= rd && (beat == 4'd0);
            end_q   <= last_rd;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= WAIT;
                        len_q <= len_eff;
                        req_q <= 1'b1;
                        beat  <= 4'd0;
                    end
                end
                WAIT: begin
                    if (bus.fmt_grant) begin
                        state <= SEND;
                        req_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (rd) begin
                        beat <= beat + 4'd1;
                        if (last_rd) state <= LAST;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                LAST: begin
                    state <= IDLE;
                    beat  <= 4'd0;
                    cnt   <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en    = rd;
    assign bus.fmt_req       = req_q;
    assign bus.fmt_valid     = valid_q;
    assign bus.fmt_start     = start_q;
    assign bus.fmt_end       = end_q;
    assign bus.fmt_data      = valid_q ? bus.fifo_rdata : '0;
    assign bus.fmt_length    = len_q;
    assign bus.pkt_cnt       = cnt;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_pkt_formatter.sv
// Directed bench for pkt_formatter with a simple FIFO read model.
module tb_pkt_formatter;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] rd_idx = 16'd0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pkt_formatter_if #(.DW(32), .FIFO_PTR_WIDE(3)) bus ();

    pkt_formatter #(.DW(32), .FIFO_PTR_WIDE(3), .MAX_CNT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // FIFO model: each read returns a tagged, incrementing word
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rdata <= 32'hC0DE_0000 | {16'h0, rd_idx};
            rd_idx <= rd_idx + 16'd1;
        end
    end

    task automatic run_pkt(input logic [3:0] len, input logic [3:0] slack,
                           input int gnt_dly, input int gap_after,
                           output int req_lat, output int nwords,
                           output int start_pos, output int end_pos,
                           output int data_err, output int gap_cyc);
        int base;
        int first;
        int last;
        int gap_left;
        bit gap_done;
        logic [31:0] exp;
        req_lat = -1; nwords = 0; start_pos = -1; end_pos = -1;
        data_err = 0; first = -1; last = -1; gap_left = 0;
        gap_done = (gap_after < 0);
        base = int'(rd_idx);
        bus.pkt_len = len;
        bus.fifo_slack = slack;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.fmt_req) begin
                req_lat = i;
                break;
            end
        end
        bus.pkt_len = 4'd0;
        repeat (gnt_dly) @(negedge clk);
        bus.fmt_grant = 1'b1;
        @(negedge clk);
        bus.fmt_grant = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.fmt_valid) begin
                exp = 32'hC0DE_0000 | 32'(base + nwords);
                if (bus.fmt_start) start_pos = nwords;
                if (bus.fmt_end) end_pos = nwords;
                if (bus.fmt_data !== exp) data_err++;
                if (first < 0) first = c;
                last = c;
                nwords++;
            end else if (bus.fmt_data !== 32'h0) begin
                data_err++;
            end
            if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) bus.downlink_ready = 1'b1;
            end else if (!gap_done && (int'(rd_idx) - base) == gap_after) begin
                bus.downlink_ready = 1'b0;
                gap_left = 2;
                gap_done = 1'b1;
            end
        end
        gap_cyc = (first < 0) ? -1 : (last - first + 1 - nwords);
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if ({bus.fifo_rd_en, bus.fmt_req, bus.fmt_valid, bus.fmt_start,
             bus.fmt_end, bus.err_underflow} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b want=0", {bus.fifo_rd_en,
                     bus.fmt_req, bus.fmt_valid, bus.fmt_start, bus.fmt_end,
                     bus.err_underflow});
        end
        n_vec++;
        if (bus.fmt_data !== 32'h0 || bus.fmt_length !== 4'h0 ||
            bus.pkt_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_values data=%h len=%h cnt=%h want 0",
                     bus.fmt_data, bus.fmt_length, bus.pkt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, nw, sp, ep, de, gc;
        logic [15:0] c0;
        c0 = bus.pkt_cnt;
        run_pkt(4'd4, 4'd4, 2, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL basic_req_latency got=%0d want=1", lat);
        end
        n_vec++;
        if (nw !== 4 || sp !== 0 || ep !== 3) begin
            n_bad++;
            $display("FAIL basic_framing words=%0d start=%0d end=%0d want 4/0/3",
                     nw, sp, ep);
        end
        n_vec++;
        if (de !== 0 || gc !== 0) begin
            n_bad++;
            $display("FAIL basic_data errs=%0d gap=%0d want 0/0", de, gc);
        end
        n_vec++;
        if (bus.pkt_cnt !== c0 + 16'd1 || bus.fmt_length !== 4'd4) begin
            n_bad++;
            $display("FAIL basic_cnt cnt=%h len=%h want %h/4", bus.pkt_cnt,
                     bus.fmt_length, c0 + 16'd1);
        end
        n_vec++;
        if (bus.err_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_no_err got=%b want=0", bus.err_underflow);
        end
    endtask

    task automatic test_occupancy;
        int lat, nw, sp, ep, de, gc;
        int seen;
        seen = 0;
        bus.pkt_len = 4'd5;
        bus.fifo_slack = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.fmt_req) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL occ_low_req got=%0d cycles want=0", seen);
        end
        bus.fifo_slack = 4'd3;
        @(negedge clk);
        n_vec++;
        if (bus.fmt_req !== 1'b1) begin
            n_bad++;
            $display("FAIL occ_ok_req got=%b want=1", bus.fmt_req);
        end
        run_pkt(4'd5, 4'd3, 0, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (nw !== 5 || ep !== 4 || de !== 0) begin
            n_bad++;
            $display("FAIL occ_pkt words=%0d end=%0d errs=%0d want 5/4/0",
                     nw, ep, de);
        end
    endtask

    task automatic test_lengths;
        int lat, nw, sp, ep, de, gc;
        int seen;
        run_pkt(4'd1, 4'd0, 1, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (nw !== 1 || sp !== 0 || ep !== 0 || de !== 0) begin
            n_bad++;
            $display("FAIL len1 words=%0d start=%0d end=%0d errs=%0d want 1/0/0/0",
                     nw, sp, ep, de);
        end
        seen = 0;
        bus.pkt_len = 4'd0;
        bus.fifo_slack = 4'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.fmt_req) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL len0_req got=%0d cycles want=0", seen);
        end
        run_pkt(4'd12, 4'd0, 1, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (bus.fmt_length !== 4'd8) begin
            n_bad++;
            $display("FAIL len12_clamp got=%0d want=8", bus.fmt_length);
        end
        n_vec++;
        if (nw !== 8 || ep !== 7 || de !== 0) begin
            n_bad++;
            $display("FAIL len12_words words=%0d end=%0d errs=%0d want 8/7/0",
                     nw, ep, de);
        end
    endtask

    task automatic test_underflow;
        int lat, nw, sp, ep, de, gc;
        run_pkt(4'd4, 4'd0, 1, 2, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (nw !== 4 || sp !== 0 || ep !== 3 || de !== 0) begin
            n_bad++;
            $display("FAIL gap_words words=%0d start=%0d end=%0d errs=%0d want 4/0/3/0",
                     nw, sp, ep, de);
        end
        n_vec++;
        if (gc !== 2) begin
            n_bad++;
            $display("FAIL gap_len got=%0d want=2", gc);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.err_underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_sticky got=%b want=1", bus.err_underflow);
        end
    endtask

    task automatic test_reset_mid;
        int lat, nw, sp, ep, de, gc;
        int words;
        bit got_req;
        words = 0;
        got_req = 1'b0;
        bus.pkt_len = 4'd8;
        bus.fifo_slack = 4'd0;
        for (int i = 0; i < 10 && !got_req; i++) begin
            @(negedge clk);
            got_req = bus.fmt_req;
        end
        bus.pkt_len = 4'd0;
        bus.fmt_grant = 1'b1;
        @(negedge clk);
        bus.fmt_grant = 1'b0;
        for (int i = 0; i < 20 && words < 2; i++) begin
            @(negedge clk);
            if (bus.fmt_valid) words++;
        end
        n_vec++;
        if (words !== 2) begin
            n_bad++;
            $display("FAIL mid_reach_word2 got=%0d want=2", words);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.fifo_rd_en, bus.fmt_req, bus.fmt_valid, bus.fmt_start,
             bus.fmt_end, bus.err_underflow} !== 6'b0 ||
            bus.fmt_data !== 32'h0 || bus.fmt_length !== 4'h0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs data=%h len=%h flags=%b want 0",
                     bus.fmt_data, bus.fmt_length, {bus.fifo_rd_en,
                     bus.fmt_req, bus.fmt_valid, bus.fmt_start, bus.fmt_end,
                     bus.err_underflow});
        end
        n_vec++;
        if (bus.pkt_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_reset_cnt got=%h want=0000", bus.pkt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_pkt(4'd3, 4'd0, 1, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (nw !== 3 || sp !== 0 || ep !== 2 || de !== 0 ||
            bus.pkt_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL mid_restart words=%0d end=%0d errs=%0d cnt=%h want 3/2/0/0001",
                     nw, ep, de, bus.pkt_cnt);
        end
    endtask

    task automatic test_wrap;
        int lat, nw, sp, ep, de, gc;
        @(negedge clk);
        force dut.cnt = 16'hFFFE;
        @(negedge clk);
        release dut.cnt;
        run_pkt(4'd1, 4'd0, 0, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (bus.pkt_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_ffff got=%h want=ffff", bus.pkt_cnt);
        end
        run_pkt(4'd1, 4'd0, 0, -1, lat, nw, sp, ep, de, gc);
        n_vec++;
        if (bus.pkt_cnt !== 16'h0000) begin
            n_bad++;
            $display("FAIL wrap_zero got=%h want=0000", bus.pkt_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pkt_len = 4'd0;
        bus.fifo_slack = 4'd8;
        bus.downlink_ready = 1'b1;
        bus.fmt_grant = 1'b0;
        test_reset();
        test_basic();
        test_occupancy();
        test_lengths();
        test_underflow();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pkt_formatter.md
PKT_FORMATTER -- requirements
Module: pkt_formatter

Interface
REQ-001 Parameter DW, default 32, meaning FIFO and packet data width.
REQ-002 Parameter FIFO_PTR_WIDE, default 3, meaning slack width minus 1 (slack is FIFO_PTR_WIDE+1 bits).
REQ-003 Parameter MAX_CNT, default 8, meaning FIFO depth in words.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pkt_len  input  4  requested packet length in words, sampled only in IDLE.
REQ-007 fifo_slack  input  FIFO_PTR_WIDE+1  free slots in the upstream FIFO; occupancy = MAX_CNT - fifo_slack.
REQ-008 downlink_ready  input  1  FIFO non-empty and out of reset.
REQ-009 fifo_rdata  input  DW  FIFO read data, valid the cycle after fifo_rd_en.
REQ-010 fifo_rd_en  output  1  FIFO read strobe.
REQ-011 fmt_req  output  1  request to the downstream arbiter for a packet slot.
REQ-012 fmt_grant  input  1  downstream grant; single-cycle pulse.
REQ-013 fmt_valid  output  1  fmt_data carries a packet word this cycle.
REQ-014 fmt_start  output  1  first word of packet.
REQ-015 fmt_end  output  1  last word of packet.
REQ-016 fmt_data  output  DW  packet word; 0 when fmt_valid is low.
REQ-017 fmt_length  output  4  latched length of the current packet.
REQ-018 pkt_cnt  output  16  number of completed packets, wraps 0xFFFF->0x0000.
REQ-019 err_underflow  output  1  sticky flag: a read was needed while FIFO was empty.

Function
REQ-020 The FSM SHALL have four states: IDLE, WAIT, SEND, LAST.
REQ-021 Effective length L = min(pkt_len, MAX_CNT); pkt_len==0 SHALL never leave IDLE.
REQ-022 IDLE->WAIT when L>=1 and occupancy>=L; L latched into fmt_length on that edge.
REQ-023 fmt_req SHALL be high exactly while in WAIT (registered; rises the cycle after the IDLE->WAIT edge).
REQ-024 WAIT->SEND on the edge where fmt_grant is sampled high; fmt_grant SHALL be ignored in every other state.
REQ-025 In SEND, fifo_rd_en = downlink_ready; beat counter increments only on a read; SEND->LAST on the edge completing read L.
REQ-026 In SEND with downlink_ready low, no read SHALL occur, the beat counter holds, and err_underflow SHALL be set to 1 until reset.
REQ-027 fmt_valid SHALL be fifo_rd_en delayed one cycle; fmt_data = fifo_rdata when fmt_valid, else 0.
REQ-028 fmt_start SHALL accompany the valid word from read 1; fmt_end the valid word from read L; both high together when L=1.
REQ-029 LAST SHALL last one cycle (carries the final valid word) and return to IDLE; pkt_cnt increments on the LAST->IDLE edge.
REQ-030 pkt_len changes outside IDLE SHALL NOT affect the packet in progress.
REQ-031 Minimum packet spacing: a new IDLE->WAIT edge SHALL occur no earlier than the cycle after LAST.

Reset
REQ-032 On rst_n low, asynchronously: state IDLE; fifo_rd_en, fmt_req, fmt_valid, fmt_start, fmt_end, err_underflow = 0; fmt_data = 0; fmt_length = 0; pkt_cnt = 0; beat counter = 0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no fmt_end and no pkt_cnt increment.

Verification
REQ-034 pkt_len=4, slack=4 (occupancy 4), grant 2 cycles after fmt_req -> 4 reads on consecutive cycles, fmt_valid for 4 cycles, fmt_start on word 1, fmt_end on word 4, pkt_cnt=1.
REQ-035 pkt_len=5, occupancy 3 -> stays IDLE, fmt_req=0; occupancy rises to 5 -> fmt_req next cycle.
REQ-036 pkt_len=1 -> single word with fmt_start=fmt_end=1; pkt_len=0 -> no request ever; pkt_len=12 -> fmt_length=8.
REQ-037 pkt_len=4, downlink_ready forced low for 2 cycles during SEND -> 2-cycle gap in fmt_valid, still exactly 4 words, err_underflow=1 held.
REQ-038 rst_n pulsed low after word 2 of an 8-word packet -> all outputs 0 immediately, pkt_cnt=0, next packet starts cleanly from IDLE.
REQ-039 pkt_cnt preloaded via 65536 packets (or forced) -> wraps 0xFFFF->0x0000.
